// File: rtl/fp_div_pkg.sv
// Shared types, constants and operand classification for the iterative FP divider.
package fp_div_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int BIAS      = (1 << (DEF_EXP_W - 1)) - 1;
    localparam int QB        = DEF_MAN_W + 4;
    localparam logic [DEF_EXP_W+DEF_MAN_W:0] QNAN =
        {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic                 sign;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_MAN_W-1:0] man;
    } fp_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    // Exponent field of zero is treated as zero, so denormal operands are flushed.
    function automatic fp_class_t classify(input logic [15:0] e, input logic [63:0] m, input int ew);
        fp_class_t c;
        logic      ones;
        ones      = (e == 16'((1 << ew) - 1));
        c.is_zero = (e == 16'd0);
        c.is_inf  = ones && (m == 64'd0);
        c.is_nan  = ones && (m != 64'd0);
        return c;
    endfunction

endpackage

// File: rtl/fp_div_round.sv
// Normalises the raw restoring-division quotient, rounds to nearest even and clamps the exponent.
module fp_div_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [MAN_W+3:0]        q,
    input  logic                    rem_nz,
    input  logic                    sign,
    input  logic signed [EXP_W+1:0] exp,
    output logic [EXP_W+MAN_W:0]    result,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] ZERO = '0;

    logic [MAN_W-1:0]     frac0;
    logic [MAN_W-1:0]     frac;
    logic                 guard;
    logic                 sticky;
    logic                 inc;
    logic                 carry;
    logic signed [EW-1:0] e_adj;
    logic signed [EW-1:0] e_fin;

    // Quotient of two 1.x mantissas lies in (0.5, 2), so at most one left shift is needed;
    // a rounding carry out of the fraction leaves frac at zero, i.e. mantissa 1.0.
    always_comb begin
        if (q[MAN_W+3]) begin
            frac0  = q[MAN_W+2:3];
            guard  = q[2];
            sticky = (|q[1:0]) | rem_nz;
            e_adj  = exp;
        end else begin
            frac0  = q[MAN_W+1:2];
            guard  = q[1];
            sticky = q[0] | rem_nz;
            e_adj  = exp - ONE;
        end
        inc           = guard & (sticky | frac0[0]);
        {carry, frac} = {1'b0, frac0} + {{MAN_W{1'b0}}, inc};
        e_fin         = carry ? (e_adj + ONE) : e_adj;
        overflow      = (e_fin >= EMAX);
        underflow     = (e_fin <= ZERO);
        if (overflow) begin
            result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (underflow) begin
            result = {sign, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            result = {sign, e_fin[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider, result = a / b, one restoring-division quotient bit per clock
// with valid/ready handshakes on both the operand and the result side.
module fp_div_iter
    import fp_div_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 exception,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW    = EXP_W + 2;
    localparam int MW    = MAN_W + 1;
    localparam int RW    = MAN_W + 2;
    localparam int QBN   = MAN_W + 4;
    localparam int BIASN = (1 << (EXP_W - 1)) - 1;
    localparam int CW    = $clog2(QBN);

    state_t               state;
    logic                 sign_r;
    logic signed [EW-1:0] exp_r;
    logic [MW-1:0]        mb_r;
    logic [RW-1:0]        rem_r;
    logic [QBN-1:0]       q_r;
    logic [CW-1:0]        cnt;

    logic                 sa;
    logic                 sb;
    logic [EXP_W-1:0]     ea;
    logic [EXP_W-1:0]     eb;
    logic [MAN_W-1:0]     fa;
    logic [MAN_W-1:0]     fb;
    fp_class_t            ca;
    fp_class_t            cb;

    logic                 spec_hit;
    logic                 spec_exc;
    logic [W-1:0]         spec_res;
    logic                 fits;
    logic [RW-1:0]        diff;
    logic [W-1:0]         rnd_result;
    logic                 rnd_ovf;
    logic                 rnd_unf;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign ca           = classify(16'(ea), 64'(fa), EXP_W);
    assign cb           = classify(16'(eb), 64'(fb), EXP_W);
    assign in_ready     = (state == IDLE);

    // Special operands resolve straight from classification; the invalid cases take priority,
    // and inf/0 is an infinite quotient rather than a divide-by-zero fault.
    always_comb begin
        spec_hit = 1'b1;
        spec_exc = 1'b0;
        spec_res = '0;
        if (ca.is_nan || cb.is_nan || (ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
            spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            spec_exc = 1'b1;
        end else if (ca.is_inf) begin
            spec_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cb.is_zero) begin
            spec_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_exc = 1'b1;
        end else if (ca.is_zero || cb.is_inf) begin
            spec_res = {sa ^ sb, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    assign fits = (rem_r >= RW'(mb_r));
    assign diff = rem_r - RW'(mb_r);

    fp_div_round #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .q        (q_r),
        .rem_nz   (|rem_r),
        .sign     (sign_r),
        .exp      (exp_r),
        .result   (rnd_result),
        .overflow (rnd_ovf),
        .underflow(rnd_unf)
    );

    // Remainder stays below twice the divisor, so RW bits hold it across every doubling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            mb_r      <= '0;
            rem_r     <= '0;
            q_r       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= sa ^ sb;
                        if (spec_hit) begin
                            result    <= spec_res;
                            exception <= spec_exc;
                            overflow  <= 1'b0;
                            underflow <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            exp_r <= EW'(ea) - EW'(eb) + EW'(BIASN);
                            rem_r <= RW'({1'b1, fa});
                            mb_r  <= {1'b1, fb};
                            q_r   <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_r <= fits ? (diff << 1) : (rem_r << 1);
                    q_r   <= {q_r[QBN-2:0], fits};
                    if (cnt == CW'(QBN - 1)) begin
                        state <= NORM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                NORM: begin
                    result    <= rnd_result;
                    exception <= 1'b0;
                    overflow  <= rnd_ovf;
                    underflow <= rnd_unf;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        result    <= '0;
                        exception <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: directed IEEE cases plus randomized operands against an
// integer-arithmetic reference, back-pressure and reset abort.
module tb_fp_div_iter;
    import fp_div_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        exception;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        special;
        logic [31:0] r;
        logic        exc;
        logic        ovf;
        logic        unf;
    } ref_t;

    fp_div_iter dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .exception(exception),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference: exact integer quotient, then round-to-nearest-even on the real-valued result.
    function automatic ref_t model(input logic [31:0] x, input logic [31:0] y);
        ref_t   o;
        logic   s, xz, yz, xi, yi, xn, yn, guard, sticky;
        int     ex, ey, e;
        longint mx, my, num, q, rem, man;
        o  = '0;
        o.special = 1'b1;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = longint'(x[22:0]);
        my = longint'(y[22:0]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (mx == 0);
        yi = (ey == 255) && (my == 0);
        xn = (ex == 255) && (mx != 0);
        yn = (ey == 255) && (my != 0);
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            o.r = 32'h7FC00000;
            o.exc = 1'b1;
            return o;
        end
        if (xi) begin
            o.r = {s, 8'hFF, 23'h0};
            return o;
        end
        if (yz) begin
            o.r = {s, 8'hFF, 23'h0};
            o.exc = 1'b1;
            return o;
        end
        if (xz || yi) begin
            o.r = {s, 31'h0};
            return o;
        end
        o.special = 1'b0;
        mx  = mx + (longint'(1) << 23);
        my  = my + (longint'(1) << 23);
        num = mx << 26;
        q   = num / my;
        rem = num % my;
        e   = ex - ey + 127;
        if (q >= (longint'(1) << 26)) begin
            man    = q >> 3;
            guard  = q[2];
            sticky = (q[1:0] != 2'b00) || (rem != 0);
        end else begin
            man    = q >> 2;
            guard  = q[1];
            sticky = q[0] || (rem != 0);
            e      = e - 1;
        end
        if (guard && (sticky || man[0])) man = man + 1;
        if (man == (longint'(1) << 24)) begin
            man = longint'(1) << 23;
            e   = e + 1;
        end
        if (e >= 255) begin
            o.r = {s, 8'hFF, 23'h0};
            o.ovf = 1'b1;
        end else if (e <= 0) begin
            o.r = {s, 31'h0};
            o.unf = 1'b1;
        end else begin
            o.r = {s, e[7:0], man[22:0]};
        end
        return o;
    endfunction

    function automatic logic [31:0] rand_op(input bit allow_special);
        int k;
        k = allow_special ? int'($urandom_range(0, 11)) : 11;
        case (k)
            0:       return 32'h00000000;
            1:       return 32'h80000000;
            2:       return 32'h7F800000;
            3:       return 32'hFF800000;
            4:       return 32'h7FC12345;
            5:       return 32'h00001234;
            default: return {($urandom_range(0, 1) == 1), 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // Presents one operand pair, waits (bounded) for the result; lat = -1 on timeout.
    task automatic do_div(input logic [31:0] x, input logic [31:0] y, output logic [34:0] obs, output int lat);
        for (int i = 0; i < 200 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        obs = {result, exception, overflow, underflow};
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({out_valid, result, exception, overflow, underflow} !== 36'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", {out_valid, result, exception, overflow, underflow});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
    endtask

    task automatic test_basic();
        logic [34:0] obs;
        int lat;
        do_div(32'h40C00000, 32'h40000000, obs, lat);
        checks++;
        if (obs !== {32'h40400000, 3'b000}) begin
            failures++;
            $display("FAIL basic_6_2: got %h required %h", obs, {32'h40400000, 3'b000});
        end
        checks++;
        if (lat !== QB + 2) begin
            failures++;
            $display("FAIL basic_latency: got %0d required %0d", lat, QB + 2);
        end
        release_result();
    endtask

    task automatic test_rounding();
        logic [31:0] xs [2] = '{32'h3F800000, 32'h3F800000};
        logic [31:0] ys [2] = '{32'h40400000, 32'h3F800000};
        logic [31:0] rs [2] = '{32'h3EAAAAAB, 32'h3F800000};
        logic [34:0] obs;
        int lat;
        for (int i = 0; i < 2; i++) begin
            do_div(xs[i], ys[i], obs, lat);
            checks++;
            if (obs !== {rs[i], 3'b000}) begin
                failures++;
                $display("FAIL rounding_%0d: got %h required %h", i, obs, {rs[i], 3'b000});
            end
            release_result();
        end
    endtask

    task automatic test_specials();
        logic [31:0] xs [8] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'hBF800000,
                                32'h00000000, 32'h40000000, 32'hFF800000, 32'h7FC00001};
        logic [31:0] ys [8] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h00000000,
                                32'h40000000, 32'h7F800000, 32'h40000000, 32'h3F800000};
        logic [34:0] rs [8] = '{{32'h7F800000, 3'b100}, {32'h7FC00000, 3'b100},
                                {32'h7FC00000, 3'b100}, {32'hFF800000, 3'b100},
                                {32'h00000000, 3'b000}, {32'h00000000, 3'b000},
                                {32'hFF800000, 3'b000}, {32'h7FC00000, 3'b100}};
        logic [34:0] obs;
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_div(xs[i], ys[i], obs, lat);
            checks++;
            if (obs !== rs[i]) begin
                failures++;
                $display("FAIL special_%0d: got %h required %h", i, obs, rs[i]);
            end
            checks++;
            if (lat !== 1) begin
                failures++;
                $display("FAIL special_latency_%0d: got %0d required 1", i, lat);
            end
            release_result();
        end
    endtask

    task automatic test_range();
        logic [34:0] obs;
        int lat;
        do_div(32'h7F000000, 32'h3E800000, obs, lat);
        checks++;
        if (obs !== {32'h7F800000, 3'b010}) begin
            failures++;
            $display("FAIL overflow: got %h required %h", obs, {32'h7F800000, 3'b010});
        end
        release_result();
        do_div(32'h00800000, 32'h40000000, obs, lat);
        checks++;
        if (obs !== {32'h00000000, 3'b001}) begin
            failures++;
            $display("FAIL underflow: got %h required %h", obs, {32'h00000000, 3'b001});
        end
        release_result();
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        logic [34:0] obs;
        ref_t e;
        int lat;
        for (int i = 0; i < 60; i++) begin
            x = rand_op(1'b1);
            y = rand_op(1'b1);
            e = model(x, y);
            do_div(x, y, obs, lat);
            checks++;
            if (obs !== {e.r, e.exc, e.ovf, e.unf}) begin
                failures++;
                $display("FAIL random_%0d %h/%h: got %h required %h", i, x, y, obs, {e.r, e.exc, e.ovf, e.unf});
            end
            checks++;
            if (lat !== (e.special ? 1 : QB + 2)) begin
                failures++;
                $display("FAIL random_latency_%0d: got %0d required %0d", i, lat, e.special ? 1 : QB + 2);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [34:0] obs;
        int lat;
        do_div(32'h40C00000, 32'h40000000, obs, lat);
        a = 32'h0;
        b = 32'h0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, result, exception, overflow, underflow} !== {2'b10, 32'h40400000, 3'b000}) begin
                failures++;
                $display("FAIL hold_%0d: got %h required %h", i,
                         {out_valid, in_ready, result, exception, overflow, underflow}, {2'b10, 32'h40400000, 3'b000});
            end
        end
        in_valid = 1'b0;
        release_result();
        checks++;
        if ({out_valid, in_ready, exception, overflow, underflow} !== 5'b01000) begin
            failures++;
            $display("FAIL release_idle: got %b required 01000", {out_valid, in_ready, exception, overflow, underflow});
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_spurious_result: got %b required 0", out_valid);
        end
    endtask

    task automatic test_reset_during_calc();
        logic [34:0] obs;
        int lat;
        bit seen;
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, result, exception, overflow, underflow} !== 36'h0) begin
            failures++;
            $display("FAIL abort_outputs: got %h required 0", {out_valid, result, exception, overflow, underflow});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_ready: got %b required 1", in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_result: got %b required 0", seen);
        end
        do_div(32'h40C00000, 32'h40000000, obs, lat);
        checks++;
        if (obs !== {32'h40400000, 3'b000} || lat !== QB + 2) begin
            failures++;
            $display("FAIL after_abort: got %h lat %0d required %h lat %0d", obs, lat, {32'h40400000, 3'b000}, QB + 2);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y;
        logic [34:0] obs;
        ref_t e;
        int lat;
        for (int i = 0; i < 4; i++) begin
            x = rand_op(1'b0);
            y = rand_op(1'b0);
            e = model(x, y);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready_%0d: got %b required 1", i, in_ready);
            end
            do_div(x, y, obs, lat);
            checks++;
            if (obs !== {e.r, e.exc, e.ovf, e.unf}) begin
                failures++;
                $display("FAIL b2b_%0d %h/%h: got %h required %h", i, x, y, obs, {e.r, e.exc, e.ovf, e.unf});
            end
            release_result();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_range();
        test_random();
        test_backpressure();
        test_reset_during_calc();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
